adc_fifo_wr_arbiter: RTL and testbench
======================================

// Module: adc_fifo_wr_arbiter
// PURPOSE
//  Round-robin write-side arbiter that lets P_NCH free-running ADC channels share the write port
//  of one asynchronous FIFO. The ADC channels cannot be stalled.
//  Each channel has a 1-entry holding register. Samples are tagged with their channel index and
//  written into the FIFO in the FIFO write-clock domain, honouring wfull backpressure.
//  Samples that arrive while a channel's holding register is still occupied are dropped and counted.
// PARAMETERS
//  P_NCH      4   number of ADC channels (2..16)
//  P_NBIT_D   12  sample width per channel
//  P_NBIT_CH  2   channel-tag width; must satisfy 2**P_NBIT_CH >= P_NCH
//  P_NBIT_CNT 16  drop-counter width
// PORTS
//  clk        in   1                    FIFO write clock (wclk of the FIFO)
//  rst        in   1                    asynchronous, active-high reset
//  en         in   1                    1 = drain holding registers into FIFO
//  ch_valid   in   P_NCH                per-channel 1-cycle sample strobe
//  ch_data    in   P_NCH*P_NBIT_D       channel k sample at [k*P_NBIT_D +: P_NBIT_D]
//  fifo_full  in   1                    FIFO wfull
//  fifo_wr    out  1                    FIFO wr
//  fifo_wdata out  P_NBIT_CH+P_NBIT_D   {channel index, sample}
//  busy       out  1                    any holding register occupied
//  ovf_flag   out  P_NCH                sticky per-channel overflow flag
//  drop_cnt   out  P_NBIT_CNT           total dropped samples, saturating
//  ovf_clr    in   1                    1-cycle pulse: clear ovf_flag and drop_cnt
// BEHAVIOUR
//  - Reset (async, immediate): occupied=0, holding regs=0, ovf_flag=0, drop_cnt=0,
//    rr_ptr=P_NCH-1 so ch0 has first priority. Outputs: fifo_wr=0, fifo_wdata=0, busy=0.
//    A reset mid-operation discards pending samples; fifo_wr drops in the same cycle.
//  - Capture: ch_valid[k] at edge t loads hold[k] and sets occ[k], if occ[k]=0 or ch k is
//    granted in cycle t. Otherwise the new sample is dropped and the held (oldest) sample is kept.
//  - Drop: sets ovf_flag[k] and increments drop_cnt by the number of channels dropping this
//    cycle. drop_cnt saturates at all-ones and never wraps.
//  - Grant (combinational from registers): with en=1 and fifo_full=0, search the occupied
//    channels starting at rr_ptr+1 and wrapping modulo P_NCH. The first hit is granted.
//    fifo_wr=1 for that cycle. fifo_wdata={k[P_NBIT_CH-1:0], hold[k]}.
//    fifo_wr=0 whenever en=0, fifo_full=1 or no channel is occupied.
//    fifo_wdata=0 when fifo_wr=0.
//  - On a grant, at the edge: occ[k] clears (unless reloaded the same cycle) and rr_ptr<=k.
//  - At most one write per cycle. Latency: ch_valid at cycle t gives the earliest fifo_wr at t+1.
//  - fifo_full is sampled combinationally in the same cycle. The FIFO registers wfull after the
//    filling write, so no write is ever issued into a full FIFO.
//  - en=0: capture and overflow accounting continue; no drain.
//  - ovf_clr together with a new drop in the same cycle: the drop wins.
//    Result: the flag stays set and drop_cnt = number dropped this cycle.
//  - busy = |occ (registered state).
// TESTING
//  1. ch_valid=4'b0100, ch_data[2]=12'hABC, full=0 -> next cycle fifo_wr=1, wdata=14'h2ABC,
//     for exactly 1 cycle; busy 1->0.
//  2. All 4 channels strobe together (data 0x100..0x103) -> 4 consecutive writes in order
//     ch0,ch1,ch2,ch3. The next burst starts at ch0.
//  3. rr_ptr=1, ch1 and ch3 occupied -> ch3 is granted before ch1.
//  4. fifo_full=1 for 5 cycles, ch0 holds 0x011, ch0 strobes 0x022 -> ovf_flag[0]=1,
//     drop_cnt=1. After full drops, wdata=14'h0011.
//  5. ovf_clr in the same cycle as a drop -> flag=1, cnt=1. Preload cnt=16'hFFFF plus a drop
//     -> cnt stays 16'hFFFF.
//  6. rst pulsed while ch1 and ch2 are pending -> fifo_wr=0 and busy=0 immediately.
//     After release, a ch0+ch3 strobe is written ch0 first.

Source files
------------

// File: rtl/adc_fifo_wr_arbiter.sv
// Round-robin write arbiter: P_NCH unstallable ADC channels, each with a 1-entry holding
// register, share one FIFO write port. Samples are tagged {channel, data}; overruns are counted.
module adc_fifo_wr_arbiter #(
  parameter int P_NCH      = 4,
  parameter int P_NBIT_D   = 12,
  parameter int P_NBIT_CH  = 2,
  parameter int P_NBIT_CNT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [P_NCH-1:0]              ch_valid,
  input  logic [P_NCH*P_NBIT_D-1:0]     ch_data,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [P_NBIT_CH+P_NBIT_D-1:0] fifo_wdata,
  output logic                          busy,
  output logic [P_NCH-1:0]              ovf_flag,
  output logic [P_NBIT_CNT-1:0]         drop_cnt,
  input  logic                          ovf_clr
);

  localparam int NW = $clog2(P_NCH + 1);
  localparam logic [P_NBIT_CH-1:0] RR_INIT = P_NBIT_CH'(P_NCH - 1);

  function automatic logic [NW-1:0] popcnt(input logic [P_NCH-1:0] v);
    logic [NW-1:0] n;
    n = '0;
    for (int k = 0; k < P_NCH; k++) n = n + NW'(v[k]);
    return n;
  endfunction

  function automatic logic [P_NBIT_CNT-1:0] sat_add(input logic [P_NBIT_CNT-1:0] a,
                                                    input logic [NW-1:0] b);
    logic [P_NBIT_CNT:0] s;
    s = {1'b0, a} + (P_NBIT_CNT+1)'(b);
    return s[P_NBIT_CNT] ? '1 : s[P_NBIT_CNT-1:0];
  endfunction

  logic [P_NCH-1:0]     occ;
  logic [P_NBIT_D-1:0]  hold [P_NCH];
  logic [P_NBIT_CH-1:0] rr_ptr;

  logic                 gnt_vld;
  logic [P_NBIT_CH-1:0] gnt_idx;
  logic [P_NCH-1:0]     gnt_oh;
  logic [P_NBIT_D-1:0]  gnt_data;
  logic [P_NCH-1:0]     drop;
  logic [P_NCH-1:0]     load;

  // Grant: first occupied channel after rr_ptr, wrapping modulo P_NCH
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    gnt_data = '0;
    if (en && !fifo_full) begin
      for (int i = 1; i <= P_NCH; i++) begin
        for (int k = 0; k < P_NCH; k++) begin
          if (!gnt_vld && occ[k] && (((int'(rr_ptr) + i) % P_NCH) == k)) begin
            gnt_vld   = 1'b1;
            gnt_idx   = P_NBIT_CH'(k);
            gnt_oh[k] = 1'b1;
            gnt_data  = hold[k];
          end
        end
      end
    end
  end

  // A granted slot frees up this edge, so a same-cycle strobe into it is accepted
  assign drop = ch_valid & occ & ~gnt_oh;
  assign load = ch_valid & ~drop;

  assign fifo_wr    = gnt_vld;
  assign fifo_wdata = gnt_vld ? {gnt_idx, gnt_data} : '0;
  assign busy       = |occ;

  // Holding registers, round-robin pointer and overflow accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      rr_ptr   <= RR_INIT;
      ovf_flag <= '0;
      drop_cnt <= '0;
      for (int k = 0; k < P_NCH; k++) hold[k] <= '0;
    end else begin
      occ <= (occ & ~gnt_oh) | load;
      for (int k = 0; k < P_NCH; k++) begin
        if (load[k]) hold[k] <= ch_data[k*P_NBIT_D +: P_NBIT_D];
      end
      if (gnt_vld) rr_ptr <= gnt_idx;
      ovf_flag <= (ovf_clr ? '0 : ovf_flag) | drop;
      drop_cnt <= sat_add(ovf_clr ? '0 : drop_cnt, popcnt(drop));
    end
  end

endmodule

// File: tb/tb_adc_fifo_wr_arbiter.sv
// Bench for adc_fifo_wr_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a slot/queue-level reference model.
module tb_adc_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  ch_valid;
  logic [47:0] ch_data;
  logic        fifo_full;
  logic        fifo_wr;
  logic [13:0] fifo_wdata;
  logic        busy;
  logic [3:0]  ovf_flag;
  logic [15:0] drop_cnt;
  logic        ovf_clr;

  adc_fifo_wr_arbiter #(
    .P_NCH(4), .P_NBIT_D(12), .P_NBIT_CH(2), .P_NBIT_CNT(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_data(ch_data),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .busy(busy),
    .ovf_flag(ovf_flag), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: which slots hold a sample, what they hold, last served channel
  bit       m_occ [4];
  int       m_hold [4];
  int       m_rr;
  bit [3:0] m_ovf;
  int       m_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      m_occ[k] = 1'b0;
      m_hold[k] = 0;
    end
    m_rr = 3;
    m_ovf = 4'b0;
    m_cnt = 0;
  endfunction

  function automatic int m_grant();
    if (!en || fifo_full) return -1;
    for (int d = 1; d <= 4; d++) begin
      int c = (m_rr + d) % 4;
      if (m_occ[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else begin
      int g;
      int nd;
      g = m_grant();
      nd = 0;
      if (g >= 0) begin
        m_occ[g] = 1'b0;
        m_rr = g;
      end
      if (ovf_clr) begin
        m_ovf = 4'b0;
        m_cnt = 0;
      end
      for (int k = 0; k < 4; k++) begin
        if (ch_valid[k]) begin
          if (m_occ[k]) begin
            nd++;
            m_ovf[k] = 1'b1;
          end else begin
            m_occ[k] = 1'b1;
            m_hold[k] = int'(ch_data[k*12 +: 12]);
          end
        end
      end
      m_cnt = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
    end
  end

  task automatic compare_all();
    int g;
    int exp_wd;
    int exp_busy;
    g = m_grant();
    exp_wd = (g >= 0) ? ((g << 12) | m_hold[g]) : 0;
    exp_busy = (m_occ[0] || m_occ[1] || m_occ[2] || m_occ[3]) ? 1 : 0;
    chk("fifo_wr", int'(fifo_wr), (g >= 0) ? 1 : 0);
    chk("fifo_wdata", int'(fifo_wdata), exp_wd);
    chk("busy", int'(busy), exp_busy);
    chk("ovf_flag", int'(ovf_flag), int'(m_ovf));
    chk("drop_cnt", int'(drop_cnt), m_cnt);
  endtask

  task automatic step(input logic [3:0] v, input logic [47:0] d,
                      input logic e, input logic f, input logic c);
    @(negedge clk);
    ch_valid = v;
    ch_data = d;
    en = e;
    fifo_full = f;
    ovf_clr = c;
    #1;
    compare_all();
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  initial begin
    int exp2 [4];
    exp2 = '{'h0100, 'h1101, 'h2102, 'h3103};
    rst = 1'b1;
    en = 1'b0;
    ch_valid = 4'b0;
    ch_data = '0;
    fifo_full = 1'b0;
    ovf_clr = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr", int'(fifo_wr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wdata", int'(fifo_wdata), 0);
    chk("rst_ovf", int'(ovf_flag), 0);
    chk("rst_cnt", int'(drop_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // All four channels strobe together: served ch0..ch3, next burst from ch0 again
    step(4'b1111, {12'h103, 12'h102, 12'h101, 12'h100}, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("burst_wd", int'(fifo_wdata), exp2[i]);
    end
    step(4'b1111, {12'h203, 12'h202, 12'h201, 12'h200}, 1'b1, 1'b0, 1'b0);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("burst2_first", int'(fifo_wdata), 'h0200);
    repeat (4) step(4'b0, '0, 1'b1, 1'b0, 1'b0);

    // Single sample on ch2
    step(4'b0100, {12'h0, 12'hABC, 24'h0}, 1'b1, 1'b0, 1'b0);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_wr", int'(fifo_wr), 1);
    chk("t1_wd", int'(fifo_wdata), 'h2ABC);
    chk("t1_busy", int'(busy), 1);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_wr_off", int'(fifo_wr), 0);
    chk("t1_busy_off", int'(busy), 0);

    // Pointer at ch1, ch1+ch3 pending: ch3 wins
    step(4'b0010, {24'h0, 12'h111, 12'h0}, 1'b1, 1'b0, 1'b0);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    step(4'b1010, {12'h3A3, 12'h0, 12'h1A1, 12'h0}, 1'b0, 1'b0, 1'b0);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("rr_ch3", int'(fifo_wdata), 'h33A3);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("rr_ch1", int'(fifo_wdata), 'h11A1);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);

    // Full FIFO: second strobe on ch0 is dropped, oldest sample kept
    step(4'b0001, {36'h0, 12'h011}, 1'b1, 1'b1, 1'b0);
    step(4'b0001, {36'h0, 12'h022}, 1'b1, 1'b1, 1'b0);
    repeat (3) step(4'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("full_wr", int'(fifo_wr), 0);
    chk("full_ovf", int'(ovf_flag), 'b0001);
    chk("full_cnt", int'(drop_cnt), 1);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("full_keep_old", int'(fifo_wdata), 'h0011);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);

    // Clear coinciding with a drop, then saturation
    step(4'b0001, rnd48(), 1'b1, 1'b1, 1'b0);
    step(4'b0001, rnd48(), 1'b1, 1'b1, 1'b1);
    step(4'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("clr_drop_ovf", int'(ovf_flag), 'b0001);
    chk("clr_drop_cnt", int'(drop_cnt), 1);
    step(4'b1111, rnd48(), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16384; i++) step(4'b1111, rnd48(), 1'b1, 1'b1, 1'b0);
    step(4'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("sat_cnt", int'(drop_cnt), 'hFFFF);
    step(4'b1111, rnd48(), 1'b1, 1'b1, 1'b0);
    step(4'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("sat_hold", int'(drop_cnt), 'hFFFF);
    step(4'b0, '0, 1'b1, 1'b0, 1'b1);
    repeat (5) step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("cleared_cnt", int'(drop_cnt), 0);

    // Reset with ch1/ch2 pending
    step(4'b0110, rnd48(), 1'b0, 1'b0, 1'b0);
    step(4'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    #1;
    chk("midrst_wr", int'(fifo_wr), 0);
    chk("midrst_busy", int'(busy), 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(4'b1001, {12'hD33, 24'h0, 12'hC00}, 1'b1, 1'b0, 1'b0);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_ch0", int'(fifo_wdata), 'h0C00);
    step(4'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_ch3", int'(fifo_wdata), 'h3D33);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v;
      v = 4'($urandom) & 4'($urandom);
      step(v, rnd48(), ($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 32) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
